// File: rtl/dac_channel_arbiter.sv
// ---------------------------------------------------------------------------
// dac_channel_arbiter
// Shares one DacSpi word-transfer engine among four requesters (DAC channels
// A-D). Round-robin arbitration, drives the DacSpi word interface, waits for
// dacdone (bounded by TIMEOUT cycles), then acknowledges the served requester.
//
// Ports
//   CLK50MHZ   in   1   system clock
//   RST        in   1   asynchronous active-low reset
//   req        in   4   level request per channel, held until ack
//   req_data   in  48   12-bit value per requester, slice [12i+11:12i]
//   ack        out  4   one-cycle completion pulse to the served requester
//   err        out  1   one-cycle pulse with ack when the transfer timed out
//   busy       out  1   high whenever the arbiter is not idle
//   grant_id   out  2   current / last granted requester
//   data       out 12   DacSpi data word
//   address    out  4   DacSpi channel address, {2'b00, grant_id}
//   command    out  4   DacSpi command nibble, CMD during a transfer
//   dactrig    out  1   DacSpi one-cycle start pulse
//   dacdone    in   1   DacSpi one-cycle completion pulse
// ---------------------------------------------------------------------------
module dac_channel_arbiter #(
    parameter logic [3:0]  CMD     = 4'b0011,
    parameter int unsigned TIMEOUT = 4096,
    parameter int unsigned TW      = 13
) (
    input  logic        CLK50MHZ,
    input  logic        RST,
    input  logic [3:0]  req,
    input  logic [47:0] req_data,
    output logic [3:0]  ack,
    output logic        err,
    output logic        busy,
    output logic [1:0]  grant_id,
    output logic [11:0] data,
    output logic [3:0]  address,
    output logic [3:0]  command,
    output logic        dactrig,
    input  logic        dacdone
);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_ISSUE = 2'd1;
    localparam logic [1:0] S_WAIT  = 2'd2;
    localparam logic [1:0] S_ACK   = 2'd3;

    localparam logic [TW-1:0] CNT_LAST = TW'(TIMEOUT - 1);

    logic [1:0]    r_state;
    logic [1:0]    r_ptr;
    logic [1:0]    r_grant_id;
    logic [11:0]   r_data;
    logic [3:0]    r_address;
    logic [3:0]    r_command;
    logic          r_dactrig;
    logic [3:0]    r_ack;
    logic          r_err;
    logic          r_busy;
    logic [TW-1:0] r_cnt;

    logic [1:0]    w_state_nxt;
    logic [1:0]    w_ptr_nxt;
    logic [1:0]    w_grant_id_nxt;
    logic [11:0]   w_data_nxt;
    logic [3:0]    w_address_nxt;
    logic [3:0]    w_command_nxt;
    logic          w_dactrig_nxt;
    logic [3:0]    w_ack_nxt;
    logic          w_err_nxt;
    logic          w_busy_nxt;
    logic [TW-1:0] w_cnt_nxt;

    logic [1:0]    w_winner;
    logic [1:0]    w_cand;

    // Round-robin pick: first set req bit at ptr, ptr+1, ptr+2, ptr+3.
    // Scanning from the farthest offset down lets the nearest one win.
    always_comb begin
        w_winner = r_ptr;
        w_cand   = r_ptr;
        for (int k = 3; k >= 0; k--) begin
            w_cand = r_ptr + 2'(k);
            if (req[w_cand]) begin
                w_winner = w_cand;
            end
        end
    end

    // Next-state and next-output logic.
    always_comb begin
        w_state_nxt    = r_state;
        w_ptr_nxt      = r_ptr;
        w_grant_id_nxt = r_grant_id;
        w_data_nxt     = r_data;
        w_address_nxt  = r_address;
        w_command_nxt  = r_command;
        w_dactrig_nxt  = 1'b0;
        w_ack_nxt      = 4'b0000;
        w_err_nxt      = 1'b0;
        w_cnt_nxt      = r_cnt;

        case (r_state)
            S_IDLE: begin
                if (|req) begin
                    w_state_nxt    = S_ISSUE;
                    w_grant_id_nxt = w_winner;
                    w_data_nxt     = req_data[6'(w_winner) * 6'd12 +: 12];
                    w_address_nxt  = {2'b00, w_winner};
                    w_command_nxt  = CMD;
                    w_dactrig_nxt  = 1'b1;
                end
            end
            S_ISSUE: begin
                w_state_nxt = S_WAIT;
                w_cnt_nxt   = '0;
            end
            S_WAIT: begin
                // dacdone takes priority over an expiry in the same cycle
                if (dacdone) begin
                    w_state_nxt = S_ACK;
                    w_ack_nxt   = 4'b0001 << r_grant_id;
                end else if (r_cnt == CNT_LAST) begin
                    w_state_nxt = S_ACK;
                    w_ack_nxt   = 4'b0001 << r_grant_id;
                    w_err_nxt   = 1'b1;
                end else begin
                    w_cnt_nxt = r_cnt + TW'(1);
                end
            end
            S_ACK: begin
                w_state_nxt   = S_IDLE;
                w_ptr_nxt     = r_grant_id + 2'd1;
                w_command_nxt = 4'b0000;
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase

        w_busy_nxt = (w_state_nxt != S_IDLE);
    end

    // State and registered outputs.
    always_ff @(posedge CLK50MHZ or negedge RST) begin
        if (!RST) begin
            r_state    <= S_IDLE;
            r_ptr      <= 2'd0;
            r_grant_id <= 2'd0;
            r_data     <= 12'd0;
            r_address  <= 4'd0;
            r_command  <= 4'd0;
            r_dactrig  <= 1'b0;
            r_ack      <= 4'd0;
            r_err      <= 1'b0;
            r_busy     <= 1'b0;
            r_cnt      <= '0;
        end else begin
            r_state    <= w_state_nxt;
            r_ptr      <= w_ptr_nxt;
            r_grant_id <= w_grant_id_nxt;
            r_data     <= w_data_nxt;
            r_address  <= w_address_nxt;
            r_command  <= w_command_nxt;
            r_dactrig  <= w_dactrig_nxt;
            r_ack      <= w_ack_nxt;
            r_err      <= w_err_nxt;
            r_busy     <= w_busy_nxt;
            r_cnt      <= w_cnt_nxt;
        end
    end

    assign ack      = r_ack;
    assign err      = r_err;
    assign busy     = r_busy;
    assign grant_id = r_grant_id;
    assign data     = r_data;
    assign address  = r_address;
    assign command  = r_command;
    assign dactrig  = r_dactrig;

endmodule

// File: tb/tb_dac_channel_arbiter.sv
// ---------------------------------------------------------------------------
// tb_dac_channel_arbiter
// Self-checking bench for dac_channel_arbiter. One instance runs with the
// default TIMEOUT against a latency-programmable DacSpi model; a second
// instance with TIMEOUT=16 never sees dacdone and exercises the timeout path.
// ---------------------------------------------------------------------------
module tb_dac_channel_arbiter;

    localparam logic [3:0] CMD = 4'b0011;

    logic        clk = 1'b0;
    logic        rst_n;

    logic [3:0]  req;
    logic [47:0] req_data;
    logic [3:0]  ack;
    logic        err;
    logic        busy;
    logic [1:0]  grant_id;
    logic [11:0] data;
    logic [3:0]  address;
    logic [3:0]  command;
    logic        dactrig;
    logic        dacdone;

    logic [3:0]  req_t;
    logic [47:0] req_data_t;
    logic [3:0]  ack_t;
    logic        err_t;
    logic        busy_t;
    logic [1:0]  grant_id_t;
    logic [11:0] data_t;
    logic [3:0]  address_t;
    logic [3:0]  command_t;
    logic        dactrig_t;
    logic        dacdone_t;

    int errors = 0;
    int checks = 0;
    int m_ptr  = 0;
    int grants[$];

    // DacSpi model: dacdone pulses dac_lat cycles after dactrig (0 = never)
    int   dac_lat    = 0;
    int   dac_cd     = 0;
    logic model_done = 1'b0;
    logic stray_done = 1'b0;

    assign dacdone   = model_done | stray_done;
    assign dacdone_t = 1'b0;

    always #10 clk = ~clk;

    dac_channel_arbiter u_dut (
        .CLK50MHZ (clk),
        .RST      (rst_n),
        .req      (req),
        .req_data (req_data),
        .ack      (ack),
        .err      (err),
        .busy     (busy),
        .grant_id (grant_id),
        .data     (data),
        .address  (address),
        .command  (command),
        .dactrig  (dactrig),
        .dacdone  (dacdone)
    );

    dac_channel_arbiter #(.TIMEOUT(16), .TW(5)) u_to (
        .CLK50MHZ (clk),
        .RST      (rst_n),
        .req      (req_t),
        .req_data (req_data_t),
        .ack      (ack_t),
        .err      (err_t),
        .busy     (busy_t),
        .grant_id (grant_id_t),
        .data     (data_t),
        .address  (address_t),
        .command  (command_t),
        .dactrig  (dactrig_t),
        .dacdone  (dacdone_t)
    );

    always @(negedge clk) begin
        model_done <= 1'b0;
        if (!rst_n) begin
            dac_cd = 0;
        end else if (dac_cd > 0) begin
            dac_cd = dac_cd - 1;
            if (dac_cd == 0) model_done <= 1'b1;
        end else if (dactrig === 1'b1 && dac_lat > 0) begin
            dac_cd = dac_lat;
        end
    end

    // Expected winner straight from the rule: first set bit from ptr upward, mod 4
    function automatic int exp_winner(input int ptr, input logic [3:0] r);
        for (int k = 0; k < 4; k++) begin
            if (r[(ptr + k) % 4]) return (ptr + k) % 4;
        end
        return -1;
    endfunction

    function automatic logic [11:0] slice(input logic [47:0] d, input int i);
        return d[i*12 +: 12];
    endfunction

    task automatic wait_trig(input int max_cyc, output bit got);
        got = 1'b0;
        for (int i = 0; i < max_cyc && !got; i++) begin
            @(negedge clk);
            if (dactrig === 1'b1) got = 1'b1;
        end
    endtask

    // Drives a request pattern and checks every grant and ack against the model
    task automatic run_transfers(input logic [3:0] start, input int n_xfer,
                                 input bit reassert, input int lat);
        int acks   = 0;
        int trigs  = 0;
        int cur    = -1;
        int cd_re  = 0;
        int re_idx = 0;
        grants.delete();
        dac_lat = lat;
        req     = start;
        for (int cyc = 0; cyc < n_xfer * 40 + 20 && acks < n_xfer; cyc++) begin
            @(negedge clk);
            if (dactrig === 1'b1) begin
                trigs++;
                cur = exp_winner(m_ptr, req);
                grants.push_back(cur);
                checks++;
                if (cur < 0 || grant_id !== 2'(cur) || data !== slice(req_data, cur) ||
                    address !== {2'b00, 2'(cur)} || command !== CMD) begin
                    errors++;
                    $display("FAIL grant: got id=%0d data=%h addr=%h cmd=%h required id=%0d data=%h addr=%0d cmd=%h",
                             grant_id, data, address, command, cur,
                             (cur >= 0) ? slice(req_data, cur) : 12'h0, cur, CMD);
                end
            end
            if (ack !== 4'b0000) begin
                acks++;
                checks++;
                if (cur < 0 || ack !== (4'b0001 << cur) || err !== 1'b0) begin
                    errors++;
                    $display("FAIL ack: got ack=%b err=%b required ack=onehot(%0d) err=0", ack, err, cur);
                end
                if (cur >= 0) begin
                    m_ptr    = (cur + 1) % 4;
                    req[cur] = 1'b0;
                    if (reassert) begin
                        cd_re  = 2;
                        re_idx = cur;
                    end
                end
            end else if (cd_re > 0) begin
                cd_re--;
                if (cd_re == 0) req[re_idx] = 1'b1;
            end
        end
        req = 4'b0000;
        checks++;
        if (acks != n_xfer || trigs != n_xfer) begin
            errors++;
            $display("FAIL xfer_count: got acks=%0d trigs=%0d required %0d each", acks, trigs, n_xfer);
        end
        @(negedge clk);
    endtask

    task automatic test_reset;
        req = 4'b0; req_data = '0; req_t = 4'b0; req_data_t = '0;
        dac_lat = 0; stray_done = 1'b0;
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        checks++;
        if ({ack, err, busy, grant_id, data, address, command, dactrig} !== 30'd0) begin
            errors++;
            $display("FAIL reset_outputs: got %h required 0",
                     {ack, err, busy, grant_id, data, address, command, dactrig});
        end
        checks++;
        if ({ack_t, err_t, busy_t, grant_id_t, data_t, address_t, command_t, dactrig_t} !== 30'd0) begin
            errors++;
            $display("FAIL reset_outputs_to: got %h required 0",
                     {ack_t, err_t, busy_t, grant_id_t, data_t, address_t, command_t, dactrig_t});
        end
        rst_n = 1'b1;
        m_ptr = 0;
        repeat (2) @(negedge clk);
        checks++;
        if (busy !== 1'b0 || ack !== 4'b0) begin
            errors++;
            $display("FAIL reset_release: got busy=%b ack=%b required 0/0", busy, ack);
        end
    endtask

    task automatic test_stray_done;
        int bad = 0;
        stray_done = 1'b1;
        @(negedge clk);
        stray_done = 1'b0;
        repeat (3) begin
            @(negedge clk);
            if (busy !== 1'b0 || ack !== 4'b0 || dactrig !== 1'b0) bad++;
        end
        checks++;
        if (bad != 0) begin
            errors++;
            $display("FAIL stray_done: got %0d active cycles required 0", bad);
        end
    endtask

    task automatic test_single;
        int  n   = 0;
        bit  got = 1'b0;
        req_data = {$urandom, $urandom};
        req_data[35:24] = 12'hABC;
        dac_lat = 30;
        req = 4'b0100;
        @(negedge clk);
        checks++;
        if (dactrig !== 1'b1 || busy !== 1'b1 || grant_id !== 2'd2 || data !== 12'hABC ||
            address !== 4'h2 || command !== 4'h3) begin
            errors++;
            $display("FAIL single_issue: got trig=%b busy=%b id=%0d data=%h addr=%h cmd=%h required 1 1 2 abc 2 3",
                     dactrig, busy, grant_id, data, address, command);
        end
        for (int i = 0; i < 100 && !got; i++) begin
            @(negedge clk);
            n++;
            if (ack !== 4'b0) got = 1'b1;
        end
        checks++;
        if (!got || n != 31 || ack !== 4'b0100 || err !== 1'b0 || data !== 12'hABC || command !== 4'h3) begin
            errors++;
            $display("FAIL single_ack: got ack=%b err=%b after %0d cycles data=%h required 0100 0 after 31 data=abc",
                     ack, err, n, data);
        end
        req = 4'b0;
        @(negedge clk);
        checks++;
        if (busy !== 1'b0 || ack !== 4'b0 || command !== 4'h0 || data !== 12'hABC || address !== 4'h2) begin
            errors++;
            $display("FAIL single_idle: got busy=%b ack=%b cmd=%h data=%h addr=%h required 0 0 0 abc 2",
                     busy, ack, command, data, address);
        end
        m_ptr = 3;
    endtask

    task automatic test_round_robin;
        req_data = {$urandom, $urandom};
        run_transfers(4'b0101, 2, 1'b0, 5);
        checks++;
        if (grants.size() != 2 || grants[0] != 0 || grants[1] != 2) begin
            errors++;
            $display("FAIL rr_wrap: got %0d grants first=%0d required order 0,2",
                     grants.size(), (grants.size() > 0) ? grants[0] : -1);
        end
    endtask

    task automatic test_all_four;
        int exp_order[5] = '{0, 1, 2, 3, 0};
        int bad = 0;
        req_data = {$urandom, $urandom};
        run_transfers(4'b1111, 5, 1'b1, 4);
        for (int i = 0; i < 5; i++) begin
            if (i >= grants.size() || grants[i] != exp_order[i]) bad++;
        end
        checks++;
        if (bad != 0) begin
            errors++;
            $display("FAIL all_four_order: got %0d wrong positions of %0d grants required 0,1,2,3,0",
                     bad, grants.size());
        end
    endtask

    task automatic test_stability;
        logic [11:0] d0;
        bit got;
        int bad = 0;
        int n   = 0;
        req_data = {$urandom, $urandom};
        d0 = slice(req_data, 1);
        dac_lat = 10;
        req = 4'b0010;
        wait_trig(20, got);
        checks++;
        if (!got || grant_id !== 2'd1 || data !== d0) begin
            errors++;
            $display("FAIL stab_issue: got trig=%b id=%0d data=%h required 1 1 %h", got, grant_id, data, d0);
        end
        @(negedge clk);
        req_data = ~req_data;
        req = 4'b0000;
        got = 1'b0;
        for (int i = 0; i < 40 && !got; i++) begin
            @(negedge clk);
            n++;
            if (data !== d0 || address !== 4'h1 || command !== CMD) bad++;
            if (ack !== 4'b0) got = 1'b1;
        end
        checks++;
        if (bad != 0) begin
            errors++;
            $display("FAIL stab_data: got %0d unstable cycles required 0", bad);
        end
        checks++;
        if (!got || ack !== 4'b0010 || err !== 1'b0) begin
            errors++;
            $display("FAIL stab_ack: got ack=%b err=%b required 0010 0", ack, err);
        end
        m_ptr = 2;
        @(negedge clk);
    endtask

    task automatic test_timeout;
        bit got = 1'b0;
        int n   = 0;
        req_data_t = {$urandom, $urandom};
        req_t = 4'b1000;
        for (int i = 0; i < 10 && !got; i++) begin
            @(negedge clk);
            if (dactrig_t === 1'b1) got = 1'b1;
        end
        checks++;
        if (!got || grant_id_t !== 2'd3 || data_t !== slice(req_data_t, 3)) begin
            errors++;
            $display("FAIL to_issue: got trig=%b id=%0d data=%h required 1 3 %h",
                     got, grant_id_t, data_t, slice(req_data_t, 3));
        end
        got = 1'b0;
        for (int i = 0; i < 40 && !got; i++) begin
            @(negedge clk);
            n++;
            if (ack_t !== 4'b0) got = 1'b1;
        end
        checks++;
        if (!got || n != 17 || ack_t !== 4'b1000 || err_t !== 1'b1) begin
            errors++;
            $display("FAIL to_ack: got ack=%b err=%b %0d cycles after issue required 1000 1 after 17",
                     ack_t, err_t, n);
        end
        req_t = 4'b0;
        @(negedge clk);
        checks++;
        if (busy_t !== 1'b0 || err_t !== 1'b0 || ack_t !== 4'b0) begin
            errors++;
            $display("FAIL to_idle: got busy=%b err=%b ack=%b required 0 0 0", busy_t, err_t, ack_t);
        end
    endtask

    task automatic test_reset_mid_wait;
        bit got;
        int stray = 0;
        req_data = {$urandom, $urandom};
        dac_lat = 0;
        req = 4'b1000;
        wait_trig(20, got);
        checks++;
        if (!got || grant_id !== 2'd3) begin
            errors++;
            $display("FAIL rmw_issue: got trig=%b id=%0d required 1 3", got, grant_id);
        end
        repeat (3) @(negedge clk);
        #3 rst_n = 1'b0;
        #1;
        checks++;
        if ({ack, err, busy, grant_id, data, address, command, dactrig} !== 30'd0) begin
            errors++;
            $display("FAIL rmw_async: got %h required 0",
                     {ack, err, busy, grant_id, data, address, command, dactrig});
        end
        req = 4'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        m_ptr = 0;
        repeat (20) begin
            @(negedge clk);
            if (ack !== 4'b0 || err !== 1'b0 || busy !== 1'b0) stray++;
        end
        checks++;
        if (stray != 0) begin
            errors++;
            $display("FAIL rmw_stray: got %0d active cycles after release required 0", stray);
        end
        req_data = {$urandom, $urandom};
        run_transfers(4'b1010, 2, 1'b0, 3);
        checks++;
        if (grants.size() != 2 || grants[0] != 1 || grants[1] != 3) begin
            errors++;
            $display("FAIL rmw_ptr: got first grant %0d required order 1,3",
                     (grants.size() > 0) ? grants[0] : -1);
        end
    endtask

    task automatic test_random;
        logic [3:0] r;
        bit re;
        for (int it = 0; it < 8; it++) begin
            r  = 4'($urandom_range(1, 15));
            re = 1'($urandom_range(0, 1));
            req_data = {$urandom, $urandom};
            run_transfers(r, $countones(r) + (re ? 2 : 0), re, $urandom_range(1, 8));
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got no finish required finish within time limit");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst_n = 1'b0;
        test_reset;
        test_stray_done;
        test_single;
        test_round_robin;
        test_reset;
        test_all_four;
        test_stability;
        test_timeout;
        test_reset_mid_wait;
        test_random;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/dac_channel_arbiter.md
Name: dac_channel_arbiter

Overview:
- Shares the single DacSpi transfer engine among four independent requesters, one per DAC channel A–D.
- Each requester posts a 12-bit value; the block round-robin arbitrates, drives the DacSpi word interface (data/address/command/dactrig), waits for dacdone, and acknowledges the winner.
- Sits between control logic (cntr, waveform generators) and DacSpi; replaces cntr's direct drive of the DacSpi interface.

Parameters:
- CMD, 4'b0011, command nibble for every transfer (write and update channel n).
- TIMEOUT, 4096, max cycles to wait for dacdone after dactrig before aborting; must be ≥ 2.
- TW, 13, timeout counter width; 2^TW > TIMEOUT.

Ports:
- CLK50MHZ  in  1  system clock, 50 MHz, single clock domain.
- RST  in  1  asynchronous, active-low reset.
- req  in  4  req[i] = requester i wants channel i written; level, held until ack[i].
- req_data  in  48  value for requester i on bits [12i+11:12i].
- ack  out  4  one-cycle pulse to the served requester on completion or timeout.
- err  out  1  one-cycle pulse, coincident with ack, when the transfer timed out.
- busy  out  1  high in every state except IDLE.
- grant_id  out  2  index of the current or last granted requester.
- data  out  12  to DacSpi.
- address  out  4  to DacSpi; equals {2'b00, grant_id}.
- command  out  4  to DacSpi; equals CMD while a transfer is active.
- dactrig  out  1  to DacSpi; one-cycle start pulse.
- dacdone  in  1  from DacSpi; one-cycle completion pulse.

Behaviour:
- Reset (RST low, asynchronous): state=IDLE, ptr=0, grant_id=0, data=0, address=0, command=0, dactrig=0, ack=0, err=0, busy=0, timeout counter=0. Release is synchronous to CLK50MHZ.
- FSM states: IDLE, ISSUE, WAIT, ACK.
- IDLE, req==0: stay in IDLE.
- IDLE, req!=0: select the winner by searching ptr, ptr+1, ptr+2, ptr+3 (mod 4) and taking the first set bit.
  - On the same edge, register grant_id=winner, data=req_data slice for the winner, address={2'b00,winner}, command=CMD.
  - Next state is ISSUE.
- ISSUE: dactrig=1 for exactly this cycle; clear the timeout counter; next state is WAIT.
  - Latency: req sampled at edge k gives dactrig high in cycle k+1.
- WAIT: the counter increments each cycle.
  - dacdone=1: go to ACK with err_flag=0.
  - Counter reaches TIMEOUT-1 without dacdone: go to ACK with err_flag=1.
  - If dacdone arrives in the same cycle the counter expires, dacdone wins (err_flag=0).
- ACK: ack[grant_id]=1 for one cycle; err=err_flag; ptr=grant_id+1 (mod 4) so the served requester gets lowest priority next; next state is IDLE.
- data, address and command hold stable from the ISSUE cycle through ACK. They keep their last values in IDLE; command is driven to 0 in IDLE.
- Minimum cycles per transfer: 4 plus DacSpi latency. Back-to-back requests re-arbitrate in the IDLE cycle after ACK.
- Requester rules:
  - req and req_data are sampled only in IDLE.
  - Changes to req_data after grant are ignored for that transfer.
  - Dropping req after grant does not cancel the transfer; ack still pulses.
  - A req dropped before grant is simply not served.
  - A requester must deassert req in the cycle after ack, or it is treated as a new request.
- dacdone outside WAIT is ignored.
- Reset during WAIT aborts the transfer: no ack, no err. DacSpi is assumed reset by the same RST.
- No starvation: with all four req held, service order from reset is 0,1,2,3,0,...

Test Plan:
- Single request: req=4'b0100, req_data[35:24]=12'hABC; DacSpi model returns dacdone 30 cycles after dactrig. Required: dactrig one cycle after req; data=12'hABC, address=4'h2, command=4'h3; ack=4'b0100 one cycle after dacdone; err=0.
- Simultaneous requests: req=4'b1111 held, re-asserted after each ack. Required: grant order 0,1,2,3,0 and exactly one dactrig per ack.
- Round-robin pointer: serve 2, then assert req=4'b0101. Required: requester 0 granted before requester 2 (ptr=3 wraps to 0).
- Timeout: DacSpi model never pulses dacdone, TIMEOUT=16. Required: ack and err pulse together 16 cycles after the WAIT entry; busy falls the next cycle.
- Data stability: change req_data and drop req one cycle after dactrig. Required: data unchanged until ACK; ack still issued.
- Reset mid-WAIT: assert RST low in WAIT. Required: all outputs 0 immediately (asynchronous); after release, no stray ack; ptr=0.
